// File: rtl/sos_seq_if.sv
// sos_seq_if: request, generator handshake and status bundle for the SOS sequencer
// Fields: trig/rep_cnt/stop are requests; s_/o_ start, done and pin form the generator handshakes;
// pin_out/busy/done_sig/err are status. master = sequencer side, slave = the environment around it.
interface sos_seq_if;
    logic       trig;
    logic [3:0] rep_cnt;
    logic       stop;
    logic       s_done_sig;
    logic       o_done_sig;
    logic       s_pin_in;
    logic       o_pin_in;
    logic       s_start_sig;
    logic       o_start_sig;
    logic       pin_out;
    logic       busy;
    logic       done_sig;
    logic       err;
    modport master (
        input  trig, rep_cnt, stop, s_done_sig, o_done_sig, s_pin_in, o_pin_in,
        output s_start_sig, o_start_sig, pin_out, busy, done_sig, err
    );
    modport slave (
        output trig, rep_cnt, stop, s_done_sig, o_done_sig, s_pin_in, o_pin_in,
        input  s_start_sig, o_start_sig, pin_out, busy, done_sig, err
    );
endinterface

// File: rtl/sos_seq_ctrl.sv
// sos_seq_ctrl: S-O-S Morse sequencer with timed gaps, word repeat, generator timeout and buzzer mux
// Ports: CLK clock; RST synchronous active-high reset; bus (master) carries trig/rep_cnt/stop,
// the S and O generator start/done/pin handshakes and the pin_out/busy/done_sig/err status.
module sos_seq_ctrl #(
    parameter logic [15:0] T1MS          = 16'd49_999,
    parameter logic [9:0]  LETTER_GAP_MS = 10'd150,
    parameter logic [9:0]  WORD_GAP_MS   = 10'd700,
    parameter logic [11:0] TIMEOUT_MS    = 12'd3000
) (
    input logic       CLK,
    input logic       RST,
    sos_seq_if.master bus
);
    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] S1   = 4'd1;
    localparam logic [3:0] GAP1 = 4'd2;
    localparam logic [3:0] O_L  = 4'd3;
    localparam logic [3:0] GAP2 = 4'd4;
    localparam logic [3:0] S2   = 4'd5;
    localparam logic [3:0] WGAP = 4'd6;
    localparam logic [3:0] FIN  = 4'd7;
    localparam logic [3:0] ERR  = 4'd8;
    logic [3:0]  state, nxt;
    logic [15:0] tcnt;
    logic [11:0] ms;
    logic [11:0] gap_tgt;
    logic [3:0]  remaining;
    logic        stop_pend, pin_q, err_q;
    logic        waiting, gapping, timed, tick, gap_end, tmo, accept;
    assign waiting = state == S1 || state == O_L || state == S2;
    assign gapping = state == GAP1 || state == GAP2 || state == WGAP;
    assign timed   = waiting || gapping;
    assign tick    = tcnt == T1MS;
    assign gap_tgt = {2'b00, state == WGAP ? WORD_GAP_MS : LETTER_GAP_MS};
    // Leave on the tick that brings ms up to its target, so a gap spans exactly target ms of cycles
    assign gap_end = tick && ms + 12'd1 == gap_tgt;
    assign tmo     = tick && ms + 12'd1 == TIMEOUT_MS;
    assign accept  = state == IDLE && bus.trig;
    // done is tested before tmo so a done arriving with the timeout still advances the word
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.trig ? S1 : IDLE;
            S1:      nxt = bus.s_done_sig ? GAP1 : tmo ? ERR : S1;
            GAP1:    nxt = gap_end ? O_L : GAP1;
            O_L:     nxt = bus.o_done_sig ? GAP2 : tmo ? ERR : O_L;
            GAP2:    nxt = gap_end ? S2 : GAP2;
            S2:      nxt = bus.s_done_sig ? WGAP : tmo ? ERR : S2;
            WGAP:    nxt = !gap_end ? WGAP : (stop_pend || remaining == 4'd1) ? FIN : S1;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tcnt      <= 16'd0;
            ms        <= 12'd0;
            remaining <= 4'd0;
            stop_pend <= 1'b0;
            pin_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state     <= nxt;
            tcnt      <= (nxt != state || !timed || tick) ? 16'd0 : tcnt + 16'd1;
            ms        <= (nxt != state || !timed) ? 12'd0 : ms + {11'd0, tick};
            remaining <= accept ? bus.rep_cnt :
                         (state == WGAP && nxt == S1 && remaining != 4'd0) ? remaining - 4'd1 : remaining;
            stop_pend <= accept ? 1'b0 : (bus.stop && state != IDLE) ? 1'b1 : stop_pend;
            err_q     <= accept ? 1'b0 : nxt == ERR ? 1'b1 : err_q;
            pin_q     <= (state == S1 || state == S2) ? bus.s_pin_in : state == O_L ? bus.o_pin_in : 1'b1;
        end
    end
    assign bus.s_start_sig = state == S1 || state == S2;
    assign bus.o_start_sig = state == O_L;
    assign bus.pin_out     = pin_q;
    assign bus.busy        = state != IDLE;
    assign bus.done_sig    = state == FIN || state == ERR;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_sos_seq_ctrl.sv
// tb_sos_seq_ctrl: directed checks of the SOS sequencer with scaled-down timing
module tb_sos_seq_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    sos_seq_if ia ();
    sos_seq_if ib ();
    sos_seq_ctrl #(.T1MS(16'd9), .LETTER_GAP_MS(10'd3), .WORD_GAP_MS(10'd5), .TIMEOUT_MS(12'd100))
        u_a (.CLK(CLK), .RST(RST), .bus(ia));
    sos_seq_ctrl #(.T1MS(16'd9), .LETTER_GAP_MS(10'd3), .WORD_GAP_MS(10'd5), .TIMEOUT_MS(12'd4))
        u_b (.CLK(CLK), .RST(RST), .bus(ib));
    always #5 CLK = ~CLK;
    int n_cmp = 0;
    int n_bad = 0;
    int ev[$];
    int gaps[$];
    int ndone = 0;
    int nlow = 0;
    bit stray_s = 1'b0;
    bit stray_o = 1'b0;
    int sb_dly = 0;
    // generator models for u_a: done on the 40th start cycle, pin low on start cycles 1..20
    initial begin
        int sc, oc;
        sc = 0;
        oc = 0;
        ia.s_done_sig = 1'b0;
        ia.o_done_sig = 1'b0;
        ia.s_pin_in = 1'b1;
        ia.o_pin_in = 1'b1;
        forever begin
            @(negedge CLK);
            sc = ia.s_start_sig ? sc + 1 : 0;
            oc = ia.o_start_sig ? oc + 1 : 0;
            ia.s_done_sig = (sc == 40) || stray_s;
            ia.o_done_sig = (oc == 40) || stray_o;
            ia.s_pin_in = !(sc >= 1 && sc <= 20);
            ia.o_pin_in = !(oc >= 1 && oc <= 20);
        end
    end
    // generator models for u_b: S done after sb_dly cycles (0 = never), O done after 40
    initial begin
        int sc, oc;
        sc = 0;
        oc = 0;
        ib.s_done_sig = 1'b0;
        ib.o_done_sig = 1'b0;
        ib.s_pin_in = 1'b1;
        ib.o_pin_in = 1'b1;
        forever begin
            @(negedge CLK);
            sc = ib.s_start_sig ? sc + 1 : 0;
            oc = ib.o_start_sig ? oc + 1 : 0;
            ib.s_done_sig = (sb_dly != 0) && (sc == sb_dly);
            ib.o_done_sig = oc == 40;
        end
    end
    // monitor for u_a: start rising edges (1=S, 2=O), silent-gap run lengths, done pulses, sound cycles
    initial begin
        bit ps, po;
        int run;
        ps = 1'b0;
        po = 1'b0;
        run = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (ia.s_start_sig && !ps) ev.push_back(1);
            if (ia.o_start_sig && !po) ev.push_back(2);
            ps = ia.s_start_sig;
            po = ia.o_start_sig;
            if (ia.busy && !ia.s_start_sig && !ia.o_start_sig && !ia.done_sig) run++;
            else if (run > 0) begin
                gaps.push_back(run);
                run = 0;
            end
            if (ia.done_sig) ndone++;
            if (!ia.pin_out) nlow++;
        end
    end
    function automatic longint ev_code(input int b);
        longint c = 0;
        for (int i = b; i < ev.size(); i++) c = c * 10 + ev[i];
        return c;
    endfunction
    function automatic longint gap_code(input int b);
        longint c = 0;
        for (int i = b; i < gaps.size(); i++) c = c * 100 + gaps[i];
        return c;
    endfunction
    task automatic step;
        @(posedge CLK);
        #2;
    endtask
    task automatic trig_a(input logic [3:0] rep, input logic stp);
        @(negedge CLK);
        ia.trig = 1'b1;
        ia.stop = stp;
        ia.rep_cnt = rep;
        @(negedge CLK);
        ia.trig = 1'b0;
        ia.stop = 1'b0;
    endtask
    task automatic trig_b(input logic [3:0] rep);
        @(negedge CLK);
        ib.trig = 1'b1;
        ib.rep_cnt = rep;
        @(negedge CLK);
        ib.trig = 1'b0;
    endtask
    task automatic wait_done_a(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (ia.done_sig) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done_seen: got %0b want 1", nm, ok);
        end
    endtask
    task automatic wait_ev_a(input int target, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (ev.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_start_seen: got %0b want 1", nm, ok);
        end
    endtask
    task automatic test_reset;
        @(negedge CLK);
        n_cmp++;
        if ({ia.busy, ia.s_start_sig, ia.o_start_sig, ia.pin_out, ia.done_sig, ia.err} !== 6'b000100) begin
            n_bad++;
            $display("FAIL reset_a: got %b want 000100",
                     {ia.busy, ia.s_start_sig, ia.o_start_sig, ia.pin_out, ia.done_sig, ia.err});
        end
        n_cmp++;
        if ({ib.busy, ib.s_start_sig, ib.o_start_sig, ib.pin_out, ib.done_sig, ib.err} !== 6'b000100) begin
            n_bad++;
            $display("FAIL reset_b: got %b want 000100",
                     {ib.busy, ib.s_start_sig, ib.o_start_sig, ib.pin_out, ib.done_sig, ib.err});
        end
    endtask
    task automatic test_single_word;
        int eb = ev.size();
        int gb = gaps.size();
        int db = ndone;
        int lb = nlow;
        trig_a(4'd1, 1'b0);
        wait_done_a("single");
        n_cmp++;
        if (ia.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy_at_done: got %b want 1", ia.busy);
        end
        step();
        n_cmp++;
        if ({ia.busy, ia.done_sig} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_idle_after: got %b want 00", {ia.busy, ia.done_sig});
        end
        n_cmp++;
        if (ev_code(eb) !== 64'd121) begin
            n_bad++;
            $display("FAIL single_order: got %0d want 121", ev_code(eb));
        end
        n_cmp++;
        if (gap_code(gb) !== 64'd303050) begin
            n_bad++;
            $display("FAIL single_gaps: got %0d want 303050", gap_code(gb));
        end
        n_cmp++;
        if (ndone - db !== 1) begin
            n_bad++;
            $display("FAIL single_done_count: got %0d want 1", ndone - db);
        end
        n_cmp++;
        if (nlow - lb !== 60) begin
            n_bad++;
            $display("FAIL single_sound_cycles: got %0d want 60", nlow - lb);
        end
    endtask
    task automatic test_repeat;
        int eb = ev.size();
        int gb = gaps.size();
        int db = ndone;
        trig_a(4'd3, 1'b0);
        wait_done_a("repeat");
        step();
        n_cmp++;
        if (ev_code(eb) !== 64'd121121121) begin
            n_bad++;
            $display("FAIL repeat_order: got %0d want 121121121", ev_code(eb));
        end
        n_cmp++;
        if (gap_code(gb) !== 64'd303050303050303050) begin
            n_bad++;
            $display("FAIL repeat_gaps: got %0d want 303050303050303050", gap_code(gb));
        end
        n_cmp++;
        if (ndone - db !== 1) begin
            n_bad++;
            $display("FAIL repeat_done_count: got %0d want 1", ndone - db);
        end
    endtask
    task automatic test_stop;
        int eb = ev.size();
        int db = ndone;
        trig_a(4'd0, 1'b0);
        wait_ev_a(eb + 5, "stop_o2");
        repeat (3) step();
        @(negedge CLK);
        ia.stop = 1'b1;
        @(negedge CLK);
        ia.stop = 1'b0;
        wait_done_a("stop");
        repeat (3) step();
        n_cmp++;
        if (ev_code(eb) !== 64'd121121) begin
            n_bad++;
            $display("FAIL stop_order: got %0d want 121121", ev_code(eb));
        end
        n_cmp++;
        if ({ndone - db, ia.busy} !== {32'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_end: got done=%0d busy=%b want done=1 busy=0", ndone - db, ia.busy);
        end
    endtask
    task automatic test_trig_stop_idle;
        int eb = ev.size();
        trig_a(4'd2, 1'b1);
        wait_done_a("trigstop");
        step();
        n_cmp++;
        if (ev_code(eb) !== 64'd121121) begin
            n_bad++;
            $display("FAIL trigstop_order: got %0d want 121121", ev_code(eb));
        end
    endtask
    task automatic test_stray;
        int eb = ev.size();
        int gb = gaps.size();
        int db = ndone;
        trig_a(4'd1, 1'b0);
        wait_ev_a(eb + 1, "stray_s1");
        for (int i = 0; i < 100 && ia.s_start_sig; i++) step();
        repeat (5) step();
        stray_s = 1'b1;
        ia.trig = 1'b1;
        ia.rep_cnt = 4'd5;
        step();
        stray_s = 1'b0;
        ia.trig = 1'b0;
        wait_done_a("stray");
        step();
        n_cmp++;
        if (ev_code(eb) !== 64'd121) begin
            n_bad++;
            $display("FAIL stray_order: got %0d want 121", ev_code(eb));
        end
        n_cmp++;
        if (gap_code(gb) !== 64'd303050) begin
            n_bad++;
            $display("FAIL stray_gaps: got %0d want 303050", gap_code(gb));
        end
        n_cmp++;
        if (ndone - db !== 1) begin
            n_bad++;
            $display("FAIL stray_done_count: got %0d want 1", ndone - db);
        end
    endtask
    task automatic test_reset_mid;
        int eb = ev.size();
        int db = ndone;
        trig_a(4'd0, 1'b0);
        wait_ev_a(eb + 2, "rst_o");
        repeat (5) step();
        n_cmp++;
        if ({ia.o_start_sig, ia.pin_out} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_pre_o: got %b want 10", {ia.o_start_sig, ia.pin_out});
        end
        @(negedge CLK);
        RST = 1'b1;
        step();
        n_cmp++;
        if ({ia.o_start_sig, ia.pin_out, ia.busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL rst_mid_o: got %b want 010", {ia.o_start_sig, ia.pin_out, ia.busy});
        end
        @(negedge CLK);
        RST = 1'b0;
        step();
        stray_o = 1'b1;
        step();
        stray_o = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({ia.busy, ia.s_start_sig, ia.o_start_sig, ia.pin_out, ndone - db} !== {4'b0001, 32'd0}) begin
            n_bad++;
            $display("FAIL rst_spurious_done: got busy=%b s=%b o=%b pin=%b done=%0d want 0 0 0 1 0",
                     ia.busy, ia.s_start_sig, ia.o_start_sig, ia.pin_out, ndone - db);
        end
    endtask
    task automatic test_timeout;
        int n;
        sb_dly = 0;
        trig_b(4'd1);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (ib.done_sig) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n !== 40) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d want 40", n);
        end
        n_cmp++;
        if ({ib.err, ib.s_start_sig, ib.busy} !== 3'b101) begin
            n_bad++;
            $display("FAIL timeout_err: got %b want 101", {ib.err, ib.s_start_sig, ib.busy});
        end
        step();
        n_cmp++;
        if ({ib.err, ib.busy, ib.done_sig} !== 3'b100) begin
            n_bad++;
            $display("FAIL timeout_idle: got %b want 100", {ib.err, ib.busy, ib.done_sig});
        end
        sb_dly = 40;
        trig_b(4'd1);
        n_cmp++;
        if ({ib.err, ib.busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_err_clear: got %b want 01", {ib.err, ib.busy});
        end
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (ib.done_sig) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if ({n, ib.err} !== {32'd230, 1'b0}) begin
            n_bad++;
            $display("FAIL done_beats_timeout: got cycles=%0d err=%b want 230 0", n, ib.err);
        end
    endtask
    initial begin
        ia.trig = 1'b0;
        ia.stop = 1'b0;
        ia.rep_cnt = 4'd0;
        ib.trig = 1'b0;
        ib.stop = 1'b0;
        ib.rep_cnt = 4'd0;
        repeat (3) @(posedge CLK);
        test_reset();
        @(negedge CLK);
        RST = 1'b0;
        test_single_word();
        test_repeat();
        test_stop();
        test_trig_stop_idle();
        test_stray();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sos_seq_ctrl.md
Name: sos_seq_ctrl

Overview:
- Sequencer for the Morse buzzer path. Drives the S-letter and O-letter generators through their level start / one-cycle done handshake, in the order S, O, S.
- Inserts timed silent gaps between letters and between words, and repeats the word a programmable number of times.
- Multiplexes the active generator's buzzer pin onto the single board buzzer pin, which is active-low.

Parameters:
- T1MS, 16'd49_999: clock cycles per 1 ms tick, minus one (50 MHz).
- LETTER_GAP_MS, 10'd150: silence between letters, in ms.
- WORD_GAP_MS, 10'd700: silence after each complete SOS, in ms.
- TIMEOUT_MS, 12'd3000: maximum wait for a generator's done, in ms.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- trig  in  1  one-cycle request to start a burst; ignored unless idle.
- rep_cnt  in  4  number of SOS words per burst; sampled on accepted trig; 0 = continuous.
- stop  in  1  one-cycle graceful stop request.
- s_done_sig  in  1  done pulse from the S generator.
- o_done_sig  in  1  done pulse from the O generator.
- s_pin_in  in  1  buzzer pin from the S generator.
- o_pin_in  in  1  buzzer pin from the O generator.
- s_start_sig  out  1  level start to the S generator.
- o_start_sig  out  1  level start to the O generator.
- pin_out  out  1  buzzer drive, active-low (0 = sound).
- busy  out  1  high in every state except IDLE.
- done_sig  out  1  one-cycle pulse when a burst completes.
- err  out  1  sticky timeout flag; cleared by the next accepted trig or by RST.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high; it is sampled only on the rising edge of CLK.
- Reset values:
  - state = IDLE.
  - s_start_sig = o_start_sig = 0.
  - pin_out = 1, busy = 0, done_sig = 0, err = 0.
  - All counters = 0, stop_pend = 0.
  - RST asserted mid-burst drops both starts on the same edge; pin_out returns to 1 on that edge.
- Timer:
  - 16-bit tick counter runs only in GAP and WAIT states; it is cleared on every state change.
  - Tick when the counter equals T1MS, then wrap to 0.
  - 12-bit ms counter increments per tick and is cleared on every state change.
  - A gap ends on the cycle the ms counter equals its target.
- States:
  - IDLE → S1 on trig. Latch rep_cnt into remaining, clear err and stop_pend.
  - S1, O, S2 (WAIT states):
    - Hold the corresponding start high.
    - On the edge where that generator's done = 1, drop start on that same edge and go to the next state.
    - Order: S1 → GAP1 → O → GAP2 → S2 → WGAP.
  - GAP1, GAP2: no start asserted; wait LETTER_GAP_MS.
  - WGAP: wait WORD_GAP_MS, then decide:
    - If stop_pend is set, or remaining == 1, go to FIN.
    - Otherwise decrement remaining (not when remaining == 0) and go to S1.
  - FIN: done_sig = 1 for one cycle, then IDLE.
  - ERR: entered when a WAIT state's ms counter reaches TIMEOUT_MS.
    - Drop starts and set err.
    - Pulse done_sig for one cycle, then IDLE.
- stop handling:
  - stop during busy sets stop_pend; the current word always completes.
  - stop in IDLE is ignored.
- Done pulses:
  - A done from the non-selected generator is ignored.
  - A done outside a WAIT state is ignored.
  - trig while busy is ignored.
- pin_out:
  - Registered mux: s_pin_in in S1/S2, o_pin_in in O, 1 everywhere else.
  - Latency is 1 cycle from the pin inputs.
- Simultaneous events:
  - RST has priority over everything.
  - In WAIT, done and timeout on the same cycle: done wins.
  - trig and stop on the same cycle in IDLE: trig is accepted and stop is ignored.

Test Plan:
- Single word, T1MS=9, LETTER_GAP_MS=3, WORD_GAP_MS=5, rep_cnt=1, trig; generator models return done after 40 cycles.
  - Required order: s_start, then o_start, then s_start.
  - Gaps are exactly 30 and 50 cycles with pin_out=1.
  - done_sig pulses once; busy falls the cycle after.
- rep_cnt=3: exactly 3 S-O-S words are issued, then a single done_sig.
- rep_cnt=0 with stop pulsed during the second word's O: the second word completes, then FIN; no third S1.
- Timeout: S model never returns done, TIMEOUT_MS=4, T1MS=9.
  - After 40 cycles in S1: err=1, s_start=0, done_sig pulse, IDLE.
  - The next trig clears err.
- RST asserted during O: the next edge gives o_start=0, pin_out=1, busy=0, IDLE. A spurious o_done afterwards has no effect.
- Stray s_done during GAP1, and trig during busy: both are ignored and the sequence timing is unchanged.
